// File: rtl/clk_tick_pkg.sv
// Shared constants for the multi-channel tick generator.
// Holds the mode encodings, the default counter width and 50 MHz divisor presets.
package clk_tick_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int unsigned CNT_W_DEF = 32;

    localparam int unsigned DIV_1MS  = 50000;
    localparam int unsigned DIV_10MS = 500000;
    localparam int unsigned DIV_1S   = 50000000;

endpackage

// File: rtl/clk_tick_ch.sv
// One tick channel: wrap counter, toggle/pulse output mux and optional pulse stretch.
// Pulse stretching is built only when CLKGEN_STRETCH_EN is defined.
module clk_tick_ch
    import clk_tick_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned PULSE_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_clr,
    input  logic             en,
    input  logic             mode,
    input  logic [CNT_W-1:0] div_val,
    output logic             clk_out,
    output logic             tick_out
);

    logic [CNT_W-1:0] div_eff;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             term;
    logic             hold;

    // Divisor is used live; zero behaves like one.
    assign div_eff = (div_val == '0) ? CNT_W'(1) : div_val;
    // >= so a divisor shrinking below the current count wraps on the next edge.
    assign term    = (cnt_q >= (div_eff - CNT_W'(1)));
    assign hold    = sync_clr | ~en;

`ifdef CLKGEN_STRETCH_EN
    localparam int unsigned SW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [CNT_W:0] PW_EXT = (CNT_W + 1)'(PULSE_W);

    logic [SW-1:0] str_q, str_d;
    logic [SW-1:0] str_load;

    // Extra high cycles after the term edge: min(PULSE_W, div_eff) - 1.
    always_comb begin
        str_load = '0;
        if ({1'b0, div_eff} >= PW_EXT) begin
            str_load = SW'(PULSE_W - 1);
        end else begin
            str_load = SW'(div_eff - CNT_W'(1));
        end
    end
`endif

    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        clk_d  = 1'b0;
`ifdef CLKGEN_STRETCH_EN
        str_d  = '0;
`endif
        if (!hold) begin
            cnt_d  = term ? '0 : cnt_q + CNT_W'(1);
            tick_d = term;
            if (mode == MODE_TOGGLE) begin
                clk_d = clk_q ^ term;
            end else begin
`ifdef CLKGEN_STRETCH_EN
                if (term) begin
                    clk_d = 1'b1;
                    str_d = str_load;
                end else if (str_q != '0) begin
                    clk_d = 1'b1;
                    str_d = str_q - SW'(1);
                end
`else
                clk_d = term;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

`ifdef CLKGEN_STRETCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            str_q <= '0;
        end else begin
            str_q <= str_d;
        end
    end
`endif

    assign clk_out  = clk_q;
    assign tick_out = tick_q;

endmodule

// File: rtl/clk_tick_gen.sv
// Multi-channel tick / clock-enable generator, one clk_tick_ch per channel.
// Define CLKGEN_STRETCH_EN to stretch pulse-mode outputs to PULSE_W cycles.
module clk_tick_gen
    import clk_tick_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned PULSE_W = 1
) (
    input  logic                    MCLK,
    input  logic                    RESET_IN,
    input  logic                    SYNC_CLR,
    input  logic [NUM_CH-1:0]       CH_EN,
    input  logic [NUM_CH-1:0]       CH_MODE,
    input  logic [NUM_CH*CNT_W-1:0] DIV_VAL,
    output logic [NUM_CH-1:0]       CLK_OUT,
    output logic [NUM_CH-1:0]       TICK_OUT
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_tick_ch #(
            .CNT_W   (CNT_W),
            .PULSE_W (PULSE_W)
        ) u_ch (
            .clk      (MCLK),
            .rst      (RESET_IN),
            .sync_clr (SYNC_CLR),
            .en       (CH_EN[i]),
            .mode     (CH_MODE[i]),
            .div_val  (DIV_VAL[i*CNT_W +: CNT_W]),
            .clk_out  (CLK_OUT[i]),
            .tick_out (TICK_OUT[i])
        );
    end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Self-checking bench for clk_tick_gen: directed scenarios plus a randomized run
// against an arithmetic reference model (stretch scenario when CLKGEN_STRETCH_EN is defined).
module tb_clk_tick_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int PW     = 3;

    logic                    mclk = 1'b0;
    logic                    reset_in;
    logic                    sync_clr;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       ch_mode;
    logic [NUM_CH*CNT_W-1:0] div_val;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick_out;

    int checks = 0;
    int errors = 0;

    // Reference model state: position within the current period per channel.
    longint            m_pos [NUM_CH];
    int                m_rem [NUM_CH];
    logic [NUM_CH-1:0] m_clk;
    logic [NUM_CH-1:0] m_tick;

    clk_tick_gen #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PULSE_W (PW)
    ) dut (
        .MCLK     (mclk),
        .RESET_IN (reset_in),
        .SYNC_CLR (sync_clr),
        .CH_EN    (ch_en),
        .CH_MODE  (ch_mode),
        .DIV_VAL  (div_val),
        .CLK_OUT  (clk_out),
        .TICK_OUT (tick_out)
    );

    always #5 mclk = ~mclk;

    function automatic void model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            m_pos[i] = 0;
            m_rem[i] = 0;
        end
        m_clk  = '0;
        m_tick = '0;
    endfunction

    function automatic void model_edge();
        if (reset_in || sync_clr) begin
            model_clear();
            return;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            longint d;
            longint deff;
            bit     t;
            d    = longint'(div_val[i*CNT_W +: CNT_W]);
            deff = (d == 0) ? 1 : d;
            if (!ch_en[i]) begin
                m_pos[i]  = 0;
                m_rem[i]  = 0;
                m_clk[i]  = 1'b0;
                m_tick[i] = 1'b0;
            end else begin
                t         = (m_pos[i] >= deff - 1);
                m_pos[i]  = t ? 0 : m_pos[i] + 1;
                m_tick[i] = t;
                if (!ch_mode[i]) begin
                    m_clk[i] = m_clk[i] ^ t;
                    m_rem[i] = 0;
                end else begin
`ifdef CLKGEN_STRETCH_EN
                    if (t) begin
                        m_rem[i] = int'(((PW < deff) ? PW : deff) - 1);
                        m_clk[i] = 1'b1;
                    end else if (m_rem[i] > 0) begin
                        m_rem[i] = m_rem[i] - 1;
                        m_clk[i] = 1'b1;
                    end else begin
                        m_clk[i] = 1'b0;
                    end
`else
                    m_clk[i] = t;
`endif
                end
            end
        end
    endfunction

    task automatic step();
        @(posedge mclk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        reset_in = 1'b1;
        sync_clr = 1'b0;
        model_clear();
        step();
        step();
        reset_in = 1'b0;
    endtask

    task automatic set_div(input int ch, input int unsigned v);
        div_val[ch*CNT_W +: CNT_W] = v;
    endtask

    task automatic test_reset();
        ch_en   = '1;
        ch_mode = '1;
        div_val = '0;
        apply_reset();
        checks++;
        if (clk_out !== 4'h0 || tick_out !== 4'h0) begin
            errors++;
            $display("FAIL reset_state clk=%b tick=%b required 0000/0000", clk_out, tick_out);
        end
        step();
        checks++;
        if (clk_out !== 4'hF || tick_out !== 4'hF) begin
            errors++;
            $display("FAIL div0_pulse_run clk=%b tick=%b required 1111/1111", clk_out, tick_out);
        end
        #3;
        reset_in = 1'b1;
        model_clear();
        #1;
        checks++;
        if (clk_out !== 4'h0 || tick_out !== 4'h0) begin
            errors++;
            $display("FAIL async_reset clk=%b tick=%b required 0000/0000", clk_out, tick_out);
        end
        step();
        reset_in = 1'b0;
    endtask

    task automatic test_pulse_div4();
        ch_en   = 4'b0001;
        ch_mode = 4'b0001;
        div_val = '0;
        set_div(0, 4);
        apply_reset();
        for (int e = 1; e <= 12; e++) begin
            logic exp_v;
            step();
            exp_v = (e % 4 == 0);
            checks++;
            if (tick_out[0] !== exp_v || clk_out[0] !== exp_v) begin
                errors++;
                $display("FAIL pulse_div4 edge %0d tick=%b clk=%b required %b", e, tick_out[0],
                         clk_out[0], exp_v);
            end
        end
    endtask

    task automatic test_toggle_div3();
        ch_en   = 4'b0010;
        ch_mode = 4'b0000;
        div_val = '0;
        set_div(1, 3);
        apply_reset();
        for (int e = 1; e <= 12; e++) begin
            logic exp_c;
            logic exp_t;
            step();
            exp_c = ((e / 3) % 2 == 1);
            exp_t = (e % 3 == 0);
            checks++;
            if (clk_out[1] !== exp_c || tick_out[1] !== exp_t) begin
                errors++;
                $display("FAIL toggle_div3 edge %0d clk=%b tick=%b required %b/%b", e,
                         clk_out[1], tick_out[1], exp_c, exp_t);
            end
        end
    endtask

    task automatic test_div01();
        ch_en   = 4'b1111;
        ch_mode = 4'b0011;
        div_val = '0;
        set_div(1, 1);
        set_div(3, 1);
        apply_reset();
        for (int e = 1; e <= 8; e++) begin
            logic [3:0] exp_c;
            step();
            exp_c = {(e % 2 == 1), (e % 2 == 1), 2'b11};
            checks++;
            if (clk_out !== exp_c || tick_out !== 4'hF) begin
                errors++;
                $display("FAIL div01 edge %0d clk=%b tick=%b required %b/1111", e, clk_out,
                         tick_out, exp_c);
            end
        end
    endtask

    task automatic test_shrink();
        ch_en   = 4'b0001;
        ch_mode = 4'b0001;
        div_val = '0;
        set_div(0, 10);
        apply_reset();
        for (int e = 1; e <= 14; e++) begin
            logic exp_t;
            if (e == 8) set_div(0, 3);
            step();
            exp_t = (e >= 8) && ((e - 8) % 3 == 0);
            checks++;
            if (tick_out[0] !== exp_t) begin
                errors++;
                $display("FAIL div_shrink edge %0d tick=%b required %b", e, tick_out[0], exp_t);
            end
        end
    endtask

    task automatic test_sync_clr();
        int divs [NUM_CH] = '{2, 3, 5, 7};
        ch_en   = 4'b1111;
        ch_mode = 4'b1111;
        for (int i = 0; i < NUM_CH; i++) set_div(i, divs[i]);
        apply_reset();
        repeat ($urandom_range(4, 20)) step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        checks++;
        if (clk_out !== 4'h0 || tick_out !== 4'h0) begin
            errors++;
            $display("FAIL sync_clr_zero clk=%b tick=%b required 0000/0000", clk_out, tick_out);
        end
        for (int e = 1; e <= 14; e++) begin
            logic [3:0] exp_v;
            step();
            for (int i = 0; i < NUM_CH; i++) exp_v[i] = (e % divs[i] == 0);
            checks++;
            if (tick_out !== exp_v || clk_out !== exp_v) begin
                errors++;
                $display("FAIL sync_realign edge %0d tick=%b clk=%b required %b", e, tick_out,
                         clk_out, exp_v);
            end
        end
    endtask

`ifdef CLKGEN_STRETCH_EN
    task automatic test_stretch();
        ch_en   = 4'b0011;
        ch_mode = 4'b0011;
        div_val = '0;
        set_div(0, 8);
        set_div(1, 2);
        apply_reset();
        for (int e = 1; e <= 16; e++) begin
            logic [1:0] exp_c;
            logic [1:0] exp_t;
            step();
            exp_c = {(e >= 2), (e >= 8) && (e % 8 < 3)};
            exp_t = {(e % 2 == 0), (e % 8 == 0)};
            checks++;
            if (clk_out[1:0] !== exp_c || tick_out[1:0] !== exp_t) begin
                errors++;
                $display("FAIL stretch edge %0d clk=%b tick=%b required %b/%b", e,
                         clk_out[1:0], tick_out[1:0], exp_c, exp_t);
            end
        end
    endtask
`endif

    task automatic test_random();
        ch_en   = '1;
        ch_mode = 4'($urandom);
        for (int i = 0; i < NUM_CH; i++) set_div(i, $urandom_range(0, 9));
        apply_reset();
        for (int n = 0; n < 1500; n++) begin
            reset_in = ($urandom_range(0, 199) == 0);
            sync_clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0) ch_en = 4'($urandom);
            if ($urandom_range(0, 14) == 0) ch_mode = 4'($urandom);
            if ($urandom_range(0, 9) == 0) set_div($urandom_range(0, 3), $urandom_range(0, 9));
            step();
            checks++;
            if (clk_out !== m_clk || tick_out !== m_tick) begin
                errors++;
                $display("FAIL random cycle %0d clk=%b tick=%b required %b/%b", n, clk_out,
                         tick_out, m_clk, m_tick);
            end
        end
        reset_in = 1'b0;
        sync_clr = 1'b0;
    endtask

    initial begin
        reset_in = 1'b1;
        sync_clr = 1'b0;
        ch_en    = '0;
        ch_mode  = '0;
        div_val  = '0;
        model_clear();
        test_reset();
        test_pulse_div4();
        test_toggle_div3();
        test_div01();
        test_shrink();
        test_sync_clr();
`ifdef CLKGEN_STRETCH_EN
        test_stretch();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
